// File: rtl/encoder_83_stream.sv
// encoder_83_stream: 8-to-3 priority encoder with valid/ready input, 2-entry result queue and saturating error counter
// ports: sys_clk, sys_rst (async, active-high); in_valid/in_ready/in_data input word handshake;
//        out_valid/out_ready/out_code/out_err/out_zero queue head; err_cnt count of non-one-hot accepts
module encoder_83_stream #(
  parameter int CNT_W    = 8,
  parameter bit PRIO_MSB = 1'b1
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_code,
  output logic             out_err,
  output logic             out_zero,
  output logic [CNT_W-1:0] err_cnt
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t state, state_nx;
  logic [2:0] enc_code;
  logic [4:0] enc, q0, q1;
  logic push, pop;
  // later matches overwrite earlier ones, so the scan order selects the priority
  always_comb begin
    enc_code = '0;
    for (int i = 0; i < 8; i++) begin
      if (PRIO_MSB && in_data[i]) enc_code = 3'(i);
      if (!PRIO_MSB && in_data[7 - i]) enc_code = 3'(7 - i);
    end
  end
  assign enc  = {enc_code, !$onehot(in_data), in_data == 8'h00};
  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) state <= EMPTY;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (state == EMPTY) state_nx = push ? ONE : EMPTY;
    if (state == ONE) state_nx = (push && !pop) ? TWO : (pop && !push) ? EMPTY : ONE;
    if (state == TWO) state_nx = pop ? ONE : TWO;
  end
  always_comb begin
    in_ready  = state != TWO;
    out_valid = state != EMPTY;
    {out_code, out_err, out_zero} = out_valid ? q0 : 5'b0;
  end
  // q0 is the head; q1 only holds a result while the queue is full
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      q0      <= '0;
      q1      <= '0;
      err_cnt <= '0;
    end else begin
      q0 <= (state == TWO && pop) ? q1 : (push && (state == EMPTY || pop)) ? enc : q0;
      q1 <= (push && state == ONE && !pop) ? enc : q1;
      if (push && enc[1] && err_cnt != {CNT_W{1'b1}}) err_cnt <= err_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_encoder_83_stream.sv
// tb_encoder_83_stream: checks two encoder configurations (MSB/8-bit count, LSB/2-bit count) against a queue model
module tb_encoder_83_stream;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic a_in_ready, a_out_valid, a_out_err, a_out_zero;
  logic b_in_ready, b_out_valid, b_out_err, b_out_zero;
  logic [2:0] a_out_code, b_out_code;
  logic [7:0] a_err_cnt;
  logic [1:0] b_err_cnt;
  logic [23:0] obs;
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0] ca;
    logic [2:0] cb;
    logic       err;
    logic       zero;
  } ent_t;
  ent_t q[$];
  int cnt_a = 0;
  int cnt_b = 0;

  always #5 clk = ~clk;

  encoder_83_stream dut_a (
    .sys_clk(clk), .sys_rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_code(a_out_code), .out_err(a_out_err),
    .out_zero(a_out_zero), .err_cnt(a_err_cnt)
  );
  encoder_83_stream #(.CNT_W(2), .PRIO_MSB(1'b0)) dut_b (
    .sys_clk(clk), .sys_rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_code(b_out_code), .out_err(b_out_err),
    .out_zero(b_out_zero), .err_cnt(b_err_cnt)
  );

  assign obs = {a_out_valid, a_in_ready, a_out_code, a_out_err, a_out_zero, a_err_cnt,
                b_out_valid, b_in_ready, b_out_code, b_out_err, b_out_zero, b_err_cnt};

  function automatic ent_t encode(logic [7:0] d);
    ent_t e;
    e = '0;
    e.zero = d == 8'h00;
    e.err  = $countones(d) != 1;
    for (int i = 7; i >= 0; i--) if (d[i]) begin e.ca = 3'(i); break; end
    for (int i = 0; i < 8; i++) if (d[i]) begin e.cb = 3'(i); break; end
    return e;
  endfunction

  function automatic logic [23:0] expected();
    ent_t h;
    logic v, r;
    v = q.size() > 0;
    r = q.size() < 2;
    h = v ? q[0] : '0;
    return {v, r, h.ca, h.err, h.zero, 8'(cnt_a), v, r, h.cb, h.err, h.zero, 2'(cnt_b)};
  endfunction

  // advances one clock, applying the handshake rules to the model, and returns 1 time unit after the edge
  task automatic tick();
    bit acc, pp;
    ent_t e;
    acc = in_valid && q.size() < 2;
    pp  = q.size() > 0 && out_ready;
    e   = encode(in_data);
    @(posedge clk);
    if (!rst) begin
      if (pp) void'(q.pop_front());
      if (acc) begin
        q.push_back(e);
        if (e.err) begin
          cnt_a = cnt_a < 255 ? cnt_a + 1 : cnt_a;
          cnt_b = cnt_b < 3 ? cnt_b + 1 : cnt_b;
        end
      end
    end
    #1;
  endtask

  task automatic model_clear();
    q.delete();
    cnt_a = 0;
    cnt_b = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_clear();
    #1;
    checks++;
    if (obs !== expected()) begin errors++; $display("FAIL reset_assert got %h want %h", obs, expected()); end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== expected()) begin errors++; $display("FAIL reset_idle got %h want %h", obs, expected()); end
    end
  endtask

  task automatic test_onehot();
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_valid = i < 8;
      in_data  = i < 8 ? 8'(1 << i) : 8'h00;
      tick();
      checks++;
      if (obs !== expected()) begin errors++; $display("FAIL onehot_%0d got %h want %h", i, obs, expected()); end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_zero_multi();
    logic [7:0] words [3];
    words = '{8'h00, 8'h81, 8'h3c};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = i < 3;
      in_data  = i < 3 ? words[i] : 8'h00;
      tick();
      checks++;
      if (obs !== expected()) begin errors++; $display("FAIL zero_multi_%0d got %h want %h", i, obs, expected()); end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [7:0] words [3];
    int idx;
    bit will;
    words = '{8'h04, 8'h10, 8'h40};
    idx = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      in_valid = idx < 3;
      in_data  = idx < 3 ? words[idx] : 8'h00;
      out_ready = c >= 4;
      will = in_valid && a_in_ready;
      tick();
      checks++;
      if (obs !== expected()) begin errors++; $display("FAIL backpressure_%0d got %h want %h", c, obs, expected()); end
      if (will) idx++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_saturate();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = i < 5;
      in_data  = 8'h03;
      tick();
      checks++;
      if (obs !== expected()) begin errors++; $display("FAIL saturate_%0d got %h want %h", i, obs, expected()); end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      in_data   = $urandom_range(0, 1) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
      tick();
      checks++;
      if (obs !== expected()) begin errors++; $display("FAIL random_%0d got %h want %h", i, obs, expected()); end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h05;
    tick();
    in_data = 8'h20;
    tick();
    checks++;
    if (obs !== expected()) begin errors++; $display("FAIL mid_full got %h want %h", obs, expected()); end
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    checks++;
    if (obs !== expected()) begin errors++; $display("FAIL mid_async got %h want %h", obs, expected()); end
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (obs !== expected()) begin errors++; $display("FAIL mid_after_%0d got %h want %h", i, obs, expected()); end
    end
  endtask

  initial begin
    test_reset();
    test_onehot();
    test_zero_multi();
    test_backpressure();
    test_saturate();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
